// File: rtl/cam_pkg.sv
// Shared types for the tcam request front-end: FSM state encoding and response layout.
// Widths here mirror the controller's default parameters.
package cam_pkg;

  localparam int CAM_WIDTH       = 32;
  localparam int CAM_DEPTH       = 16;
  localparam int CAM_INDEX_WIDTH = $clog2(CAM_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    LOOKUP,
    FETCH,
    RESP
  } tcam_lookup_state_e;

  typedef struct packed {
    logic                       hit;
    logic [CAM_INDEX_WIDTH-1:0] index;
    logic [CAM_WIDTH-1:0]       data;
  } tcam_rsp_t;

endpackage

// File: rtl/tcam_stat_cnt.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
// One-cycle update, synchronous active-high reset.
module tcam_stat_cnt
  import cam_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tcam_lookup_ctrl.sv
// Serialises write/search requests onto the tcam array and returns one response per search.
// Hit latency 3 cycles, miss 2; one request in flight. TCAM_LOOKUP_STATS_EN adds hit/miss counters.
module tcam_lookup_ctrl
  import cam_pkg::*;
#(
  parameter  int TCAM_WIDTH       = 32,
  parameter  int TCAM_DEPTH       = 16,
  localparam int TCAM_INDEX_WIDTH = $clog2(TCAM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        srch_valid,
  output logic                        srch_ready,
  input  logic [TCAM_WIDTH-1:0]       srch_key,
  input  logic [TCAM_WIDTH-1:0]       srch_mask,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [TCAM_INDEX_WIDTH-1:0] wr_idx,
  input  logic [TCAM_WIDTH-1:0]       wr_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_hit,
  output logic [TCAM_INDEX_WIDTH-1:0] rsp_index,
  output logic [TCAM_WIDTH-1:0]       rsp_data,
  output logic                        tcam_data_we,
  output logic [TCAM_INDEX_WIDTH-1:0] tcam_data_idx,
  output logic [TCAM_WIDTH-1:0]       tcam_data_i,
  output logic [TCAM_WIDTH-1:0]       tcam_data_mask,
  input  logic                        tcam_index_rdy,
  input  logic [TCAM_INDEX_WIDTH-1:0] tcam_index_o,
  input  logic [TCAM_WIDTH-1:0]       tcam_data_o
`ifdef TCAM_LOOKUP_STATS_EN
  ,
  output logic [31:0]                 stat_hits,
  output logic [31:0]                 stat_misses
`endif
);

  tcam_lookup_state_e state_q, state_d;

  // The array-facing registers double as the latched request, so they hold between operations.
  logic                        we_q, we_d;
  logic [TCAM_INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [TCAM_WIDTH-1:0]       din_q, din_d;
  logic [TCAM_WIDTH-1:0]       dmask_q, dmask_d;
  logic                        hit_q, hit_d;
  logic [TCAM_INDEX_WIDTH-1:0] rindex_q, rindex_d;
  logic [TCAM_WIDTH-1:0]       rdata_q, rdata_d;

  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    idx_d      = idx_q;
    din_d      = din_q;
    dmask_d    = dmask_q;
    hit_d      = hit_q;
    rindex_d   = rindex_q;
    rdata_d    = rdata_q;
    srch_ready = 1'b0;
    wr_ready   = 1'b0;
    rsp_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        wr_ready   = 1'b1;
        srch_ready = ~wr_valid;
        if (wr_valid) begin
          state_d = WRITE;
          we_d    = 1'b1;
          idx_d   = wr_idx;
          din_d   = wr_data;
        end else if (srch_valid) begin
          state_d = LOOKUP;
          din_d   = srch_key;
          dmask_d = srch_mask;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      LOOKUP: begin
        hit_d   = tcam_index_rdy;
        rdata_d = '0;
        if (tcam_index_rdy) begin
          rindex_d = tcam_index_o;
          idx_d    = tcam_index_o;
          state_d  = FETCH;
        end else begin
          rindex_d = '0;
          state_d  = RESP;
        end
      end
      FETCH: begin
        rdata_d = tcam_data_o;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      idx_q    <= '0;
      din_q    <= '0;
      dmask_q  <= '0;
      hit_q    <= 1'b0;
      rindex_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      din_q    <= din_d;
      dmask_q  <= dmask_d;
      hit_q    <= hit_d;
      rindex_q <= rindex_d;
      rdata_q  <= rdata_d;
    end
  end

  assign tcam_data_we   = we_q;
  assign tcam_data_idx  = idx_q;
  assign tcam_data_i    = din_q;
  assign tcam_data_mask = dmask_q;
  assign rsp_hit        = hit_q;
  assign rsp_index      = rindex_q;
  assign rsp_data       = rdata_q;

`ifdef TCAM_LOOKUP_STATS_EN
  logic lookup_hit_inc;
  logic lookup_miss_inc;

  assign lookup_hit_inc  = (state_q == LOOKUP) &  tcam_index_rdy;
  assign lookup_miss_inc = (state_q == LOOKUP) & ~tcam_index_rdy;

  tcam_stat_cnt #(.W(32)) u_stat_hits (
    .clk   (clk),
    .rst   (rst),
    .inc_i (lookup_hit_inc),
    .cnt_o (stat_hits)
  );

  tcam_stat_cnt #(.W(32)) u_stat_misses (
    .clk   (clk),
    .rst   (rst),
    .inc_i (lookup_miss_inc),
    .cnt_o (stat_misses)
  );
`endif

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// Bench for tcam_lookup_ctrl with a behavioural tcam array; responses checked by a queue-fed monitor.
module tb_tcam_lookup_ctrl;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          srch_valid, srch_ready;
  logic [W-1:0]  srch_key, srch_mask;
  logic          wr_valid, wr_ready;
  logic [IW-1:0] wr_idx;
  logic [W-1:0]  wr_data;
  logic          rsp_valid, rsp_ready, rsp_hit;
  logic [IW-1:0] rsp_index;
  logic [W-1:0]  rsp_data;
  logic          tcam_data_we;
  logic [IW-1:0] tcam_data_idx;
  logic [W-1:0]  tcam_data_i, tcam_data_mask;
  logic          tcam_index_rdy;
  logic [IW-1:0] tcam_index_o;
  logic [W-1:0]  tcam_data_o;
`ifdef TCAM_LOOKUP_STATS_EN
  logic [31:0]   stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  tcam_lookup_ctrl #(.TCAM_WIDTH(W), .TCAM_DEPTH(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .srch_valid     (srch_valid),
    .srch_ready     (srch_ready),
    .srch_key       (srch_key),
    .srch_mask      (srch_mask),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_idx         (wr_idx),
    .wr_data        (wr_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_hit        (rsp_hit),
    .rsp_index      (rsp_index),
    .rsp_data       (rsp_data),
    .tcam_data_we   (tcam_data_we),
    .tcam_data_idx  (tcam_data_idx),
    .tcam_data_i    (tcam_data_i),
    .tcam_data_mask (tcam_data_mask),
    .tcam_index_rdy (tcam_index_rdy),
    .tcam_index_o   (tcam_index_o),
    .tcam_data_o    (tcam_data_o)
`ifdef TCAM_LOOKUP_STATS_EN
    ,
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
`endif
  );

  // Behavioural array: lowest matching index wins, write lands at the clock edge.
  logic [W-1:0] mem [D] = '{default: '0};

  always @(posedge clk) begin
    if (tcam_data_we) mem[tcam_data_idx] <= tcam_data_i;
  end

  always_comb begin
    tcam_index_rdy = 1'b0;
    tcam_index_o   = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (((mem[i] ^ tcam_data_i) & tcam_data_mask) == '0) begin
        tcam_index_rdy = 1'b1;
        tcam_index_o   = IW'(i);
      end
    end
  end

  assign tcam_data_o = mem[tcam_data_idx];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          hit;
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
    int            issue;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_v = 1'b0;
  int   rise   = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) rise = cyc;
      prev_v = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got hit=%0d idx=%0d data=0x%0h, expected no response",
                   rsp_hit, rsp_index, rsp_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_hit", 64'(rsp_hit), 64'(mon_e.hit));
          chk("rsp_index", 64'(rsp_index), 64'(mon_e.idx));
          chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
          chk("rsp_latency", 64'(rise - mon_e.issue), 64'(mon_e.lat));
        end
      end
    end
  end

  task automatic wait_srch_hs(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (srch_ready) begin
        n  = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL srch_ready_timeout: got no ready in 60 cycles, expected ready");
    end
    @(posedge clk);
    #1 srch_valid = 1'b0;
  endtask

  task automatic search(input logic [W-1:0] key, input logic [W-1:0] mask, output int n, output bit ok);
    @(posedge clk);
    #1;
    srch_valid = 1'b1;
    srch_key   = key;
    srch_mask  = mask;
    wait_srch_hs(n, ok);
  endtask

  task automatic push_exp(input logic hit, input logic [IW-1:0] idx, input logic [W-1:0] data,
                          input int n, input int lat);
    exp_t e;
    e.hit = hit; e.idx = idx; e.data = data; e.issue = n; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic do_search(input logic [W-1:0] key, input logic [W-1:0] mask, input logic hit,
                           input logic [IW-1:0] idx, input logic [W-1:0] data, input int lat);
    int n;
    bit ok;
    search(key, mask, n, ok);
    if (ok) push_exp(hit, idx, data, n, lat);
  endtask

  task automatic do_write(input logic [IW-1:0] idx, input logic [W-1:0] data);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    wr_valid = 1'b1;
    wr_idx   = idx;
    wr_data  = data;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wr_ready_timeout: got no ready in 60 cycles, expected ready");
    end
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  ok;
    srch_valid = 1'b0; srch_key = '0; srch_mask = '0;
    wr_valid   = 1'b0; wr_idx   = '0; wr_data   = '0;
    rsp_ready  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_hit", 64'(rsp_hit), 64'd0);
    chk("rst_rsp_index", 64'(rsp_index), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_we", 64'(tcam_data_we), 64'd0);
    chk("rst_idx", 64'(tcam_data_idx), 64'd0);
    chk("rst_data_i", 64'(tcam_data_i), 64'd0);
    chk("rst_mask", 64'(tcam_data_mask), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Empty array: a compared bit set misses, an all-don't-care mask hits entry 0.
    do_search(32'h1, 32'h1, 1'b0, 4'd0, 32'h0, 2);
    do_search(32'h1, 32'h0, 1'b1, 4'd0, 32'h0, 3);

    do_write(4'd3, 32'h0000_00A5);
    do_search(32'h0000_00A5, 32'hFFFF_FFFF, 1'b1, 4'd3, 32'h0000_00A5, 3);

    do_write(4'd5, 32'hF0);
    do_write(4'd9, 32'hF1);
    do_search(32'hF0, 32'hF0, 1'b1, 4'd5, 32'hF0, 3);

    // Simultaneous write and search: write first, search then sees the new entry.
    wait_idle();
    @(posedge clk);
    #1;
    wr_valid = 1'b1; wr_idx = 4'd7; wr_data = 32'h77;
    srch_valid = 1'b1; srch_key = 32'h77; srch_mask = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("sim_wr_ready", 64'(wr_ready), 64'd1);
    chk("sim_srch_ready", 64'(srch_ready), 64'd0);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    chk("sim_we", 64'(tcam_data_we), 64'd1);
    chk("sim_we_idx", 64'(tcam_data_idx), 64'd7);
    chk("sim_we_data", 64'(tcam_data_i), 64'h77);
    chk("sim_srch_ready_wr", 64'(srch_ready), 64'd0);
    wait_srch_hs(n, ok);
    if (ok) push_exp(1'b1, 4'd7, 32'h77, n, 3);
    @(negedge clk);
    chk("sim_we_pulse", 64'(tcam_data_we), 64'd0);

    // Backpressure: response held stable while rsp_ready is low.
    wait_idle();
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    do_search(32'hF1, 32'hFFFF_FFFF, 1'b1, 4'd9, 32'hF1, 3);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("hold_rsp_seen", 64'(ok), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_hit", 64'(rsp_hit), 64'd1);
      chk("hold_index", 64'(rsp_index), 64'd9);
      chk("hold_data", 64'(rsp_data), 64'hF1);
      chk("hold_srch_ready", 64'(srch_ready), 64'd0);
      chk("hold_wr_ready", 64'(wr_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_srch_ready", 64'(srch_ready), 64'd1);

    // Reset while in FETCH: request aborted, no response.
    wait_idle();
    search(32'h0000_00A5, 32'hFFFF_FFFF, n, ok);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("fetch_idx", 64'(tcam_data_idx), 64'd3);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_rsp_hit", 64'(rsp_hit), 64'd0);
    chk("abort_rsp_index", 64'(rsp_index), 64'd0);
    chk("abort_rsp_data", 64'(rsp_data), 64'd0);
    chk("abort_we", 64'(tcam_data_we), 64'd0);
    chk("abort_idx", 64'(tcam_data_idx), 64'd0);
    chk("abort_data_i", 64'(tcam_data_i), 64'd0);
    chk("abort_mask", 64'(tcam_data_mask), 64'd0);
    chk("abort_srch_ready", 64'(srch_ready), 64'd1);
`ifdef TCAM_LOOKUP_STATS_EN
    chk("abort_stat_hits", 64'(stat_hits), 64'd0);
    chk("abort_stat_misses", 64'(stat_misses), 64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);

    do_search(32'h0000_00A5, 32'hFFFF_FFFF, 1'b1, 4'd3, 32'h0000_00A5, 3);
    do_search(32'hF0, 32'hF0, 1'b1, 4'd5, 32'hF0, 3);
    do_search(32'h1234, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'h0, 2);
    wait_idle();
`ifdef TCAM_LOOKUP_STATS_EN
    chk("stat_hits", 64'(stat_hits), 64'd2);
    chk("stat_misses", 64'(stat_misses), 64'd1);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
